// File: rtl/mine_pkg.sv
// Shared types and helpers for the neighbour-mine counter: result width,
// controller state encoding and cell index to row/column conversion.
package mine_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        QUERY,
        SWEEP,
        DONE
    } state_e;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } rc_t;

    function automatic rc_t pos_to_rc(input int pos, input int cols);
        rc_t rc;
        rc.row = 4'(pos / cols);
        rc.col = 4'(pos % cols);
        return rc;
    endfunction

endpackage

// File: rtl/mine_count_engine_if.sv
// Request/result bundle between the board-state logic (master) and the
// neighbour-mine counter (slave).
interface mine_count_engine_if #(
    parameter int ROWS = 6,
    parameter int COLS = 6
);
    localparam int N     = ROWS * COLS;
    localparam int POS_W = $clog2(N);

    logic [N-1:0]                   cell_mine;
    logic                           start;
    logic                           q_req;
    logic [POS_W-1:0]               q_pos;
    logic                           busy;
    logic                           out_valid;
    logic                           out_ready;
    logic [POS_W-1:0]               out_pos;
    logic [mine_pkg::CNT_W-1:0]     out_count;
    logic                           out_mine;
    logic                           done;
    logic                           err;

    modport master (
        output cell_mine, start, q_req, q_pos, out_ready,
        input  busy, out_valid, out_pos, out_count, out_mine, done, err
    );

    modport slave (
        input  cell_mine, start, q_req, q_pos, out_ready,
        output busy, out_valid, out_pos, out_count, out_mine, done, err
    );

endinterface

// File: rtl/mine_neighbor_sum.sv
// Combinational neighbour count for every cell of the snapshot; the cell
// selected by idx is presented together with its own mine bit.
module mine_neighbor_sum
    import mine_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int COLS = 6,
    localparam int N     = ROWS * COLS,
    localparam int POS_W = $clog2(N)
) (
    input  logic [N-1:0]       snap,
    input  logic [POS_W-1:0]   idx,
    output logic [CNT_W-1:0]   count,
    output logic               self_bit
);

    logic [N-1:0][CNT_W-1:0] cell_cnt;

    for (genvar p = 0; p < N; p++) begin : g_cell
        localparam rc_t RC = pos_to_rc(p, COLS);
        localparam int  R  = int'(RC.row);
        localparam int  C  = int'(RC.col);

        logic [8:0] nb;

        // 3x3 window, k=4 is the cell itself; off-board slots tie to zero
        for (genvar k = 0; k < 9; k++) begin : g_nb
            localparam int NR = R + (k / 3) - 1;
            localparam int NC = C + (k % 3) - 1;
            if (k != 4 && NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS) begin : g_in
                assign nb[k] = snap[NR * COLS + NC];
            end else begin : g_out
                assign nb[k] = 1'b0;
            end
        end

        assign cell_cnt[p] = CNT_W'($countones(nb));
    end

    assign count    = cell_cnt[idx];
    assign self_bit = snap[idx];

endmodule

// File: rtl/mine_count_engine.sv
// Neighbour-mine counter: single-cell queries and full-board sweeps over a
// snapshot of the mine map, results streamed on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start or q_req
// QUERY | presenting one query result until accepted
// SWEEP | streaming results for cells 0..N-1
// DONE  | one-cycle completion pulse, then back to IDLE
module mine_count_engine
    import mine_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int COLS = 6
) (
    input logic                 clk,
    input logic                 rst_n,
    mine_count_engine_if.slave  bus
);

    localparam int N     = ROWS * COLS;
    localparam int POS_W = $clog2(N);

    state_e             state_q, state_d;
    logic [N-1:0]       snap_q, snap_d;
    logic [POS_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_mine_q, out_mine_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   nb_count;
    logic               nb_self;

    // Fed from the next snapshot/index so the result registers load the
    // new cell on the same edge the index advances.
    mine_neighbor_sum #(.ROWS(ROWS), .COLS(COLS)) u_sum (
        .snap     (snap_d),
        .idx      (idx_d),
        .count    (nb_count),
        .self_bit (nb_self)
    );

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d  = bus.cell_mine;
                    idx_d   = '0;
                    state_d = SWEEP;
                end else if (bus.q_req) begin
                    if (int'(bus.q_pos) < N) begin
                        snap_d  = bus.cell_mine;
                        idx_d   = bus.q_pos;
                        state_d = QUERY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            QUERY: begin
                if (bus.out_ready) state_d = IDLE;
            end
            SWEEP: begin
                if (bus.out_ready) begin
                    if (idx_q == POS_W'(N - 1)) state_d = DONE;
                    else                        idx_d   = idx_q + POS_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        out_count_d = nb_count;
        out_mine_d  = nb_self;
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            out_count_q <= '0;
            out_mine_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            out_count_q <= out_count_d;
            out_mine_q  <= out_mine_d;
            err_q       <= err_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == QUERY) || (state_q == SWEEP);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.out_pos   = idx_q;
    assign bus.out_count = out_count_q;
    assign bus.out_mine  = out_mine_q;

endmodule

// File: tb/tb_mine_count_engine.sv
// Scoreboard bench for mine_count_engine: 6x6 and 4x8 instances, expected
// results from a row/column reference model, checked by per-port monitors.
module tb_mine_count_engine;
    import mine_pkg::*;

    typedef struct {
        int pos;
        int cnt;
        bit mine;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    int          vectors = 0;
    int          miscompares = 0;
    int          hs_a = 0, hs_b = 0, done_a = 0;
    int          rdy_mode_a = 0;
    longint      cyc_cnt = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [35:0] map_a;
    logic [31:0] map_b;

    mine_count_engine_if #(.ROWS(6), .COLS(6)) bus_a ();
    mine_count_engine_if #(.ROWS(4), .COLS(8)) bus_b ();

    mine_count_engine #(.ROWS(6), .COLS(6)) dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));
    mine_count_engine #(.ROWS(4), .COLS(8)) dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    function automatic exp_t ref_cell(input logic [63:0] map, input int rows, input int cols,
                                      input int pos);
        exp_t e;
        int   r, c;
        r = pos / cols;
        c = pos % cols;
        e.pos  = pos;
        e.cnt  = 0;
        e.mine = map[pos];
        for (int nr = r - 1; nr <= r + 1; nr++)
            for (int nc = c - 1; nc <= c + 1; nc++)
                if (nr >= 0 && nr < rows && nc >= 0 && nc < cols && !(nr == r && nc == c))
                    e.cnt += int'(map[nr * cols + nc]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // out_ready driver for port A: 0 = always ready, 1 = random, 2 = held low
    initial begin
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode_a)
                0:       bus_a.out_ready = 1'b1;
                1:       bus_a.out_ready = 1'($urandom_range(0, 1));
                default: bus_a.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic       held_v;
        logic [5:0] h_pos;
        logic [3:0] h_cnt;
        logic       h_mine;
        exp_t       e;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_a !== 1'b0) begin
                held_v = 1'b0;
            end else begin
                if (bus_a.done) done_a++;
                if (bus_a.out_valid) begin
                    if (held_v) begin
                        check("stall_pos_a", bus_a.out_pos, h_pos);
                        check("stall_cnt_a", bus_a.out_count, h_cnt);
                        check("stall_mine_a", bus_a.out_mine, h_mine);
                    end
                    if (bus_a.out_ready) begin
                        held_v = 1'b0;
                        if (qa.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL spurious_a: unexpected result pos %0d", bus_a.out_pos);
                        end else begin
                            e = qa.pop_front();
                            check("pos_a", bus_a.out_pos, e.pos);
                            check("count_a", bus_a.out_count, e.cnt);
                            check("mine_a", bus_a.out_mine, e.mine);
                        end
                        hs_a++;
                    end else begin
                        held_v = 1'b1;
                        h_pos  = bus_a.out_pos;
                        h_cnt  = bus_a.out_count;
                        h_mine = bus_a.out_mine;
                    end
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_b === 1'b0 && bus_b.out_valid && bus_b.out_ready) begin
                if (qb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_b: unexpected result pos %0d", bus_b.out_pos);
                end else begin
                    e = qb.pop_front();
                    check("pos_b", bus_b.out_pos, e.pos);
                    check("count_b", bus_b.out_count, e.cnt);
                    check("mine_b", bus_b.out_mine, e.mine);
                end
                hs_b++;
            end
        end
    end

    task automatic wait_hs_a(input int target);
        int cyc;
        cyc = 0;
        while (hs_a < target && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        if (hs_a < target) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_a: handshakes %0d, required %0d", hs_a, target);
        end
    endtask

    task automatic wait_hs_b(input int target);
        int cyc;
        cyc = 0;
        while (hs_b < target && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        if (hs_b < target) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_b: handshakes %0d, required %0d", hs_b, target);
        end
    endtask

    task automatic query_a(input int pos);
        int target;
        target = hs_a + 1;
        bus_a.cell_mine = map_a;
        bus_a.q_pos     = 6'(pos);
        bus_a.q_req     = 1'b1;
        qa.push_back(ref_cell(64'(map_a), 6, 6, pos));
        @(posedge clk);
        #1;
        bus_a.q_req     = 1'b0;
        bus_a.cell_mine = ~map_a;
        check("q_valid_a", bus_a.out_valid, 1);
        wait_hs_a(target);
        #1;
        check("q_idle_a", bus_a.busy, 0);
    endtask

    task automatic query_b(input int pos);
        int target;
        target = hs_b + 1;
        bus_b.cell_mine = map_b;
        bus_b.q_pos     = 5'(pos);
        bus_b.q_req     = 1'b1;
        qb.push_back(ref_cell(64'(map_b), 4, 8, pos));
        @(posedge clk);
        #1;
        bus_b.q_req     = 1'b0;
        bus_b.cell_mine = ~map_b;
        check("q_valid_b", bus_b.out_valid, 1);
        wait_hs_b(target);
        #1;
    endtask

    task automatic sweep_a(input logic [35:0] m, input bit with_query, input bit exact_timing);
        int     base, dbase;
        longint c0, c1;
        base  = hs_a;
        dbase = done_a;
        map_a = m;
        bus_a.cell_mine = m;
        bus_a.start     = 1'b1;
        if (with_query) begin
            bus_a.q_req = 1'b1;
            bus_a.q_pos = 6'd5;
        end
        for (int p = 0; p < 36; p++) qa.push_back(ref_cell(64'(m), 6, 6, p));
        @(posedge clk);
        #1;
        c0 = cyc_cnt;
        bus_a.start     = 1'b0;
        bus_a.q_req     = 1'b0;
        bus_a.cell_mine = ~m;
        check("sweep_busy", bus_a.busy, 1);
        wait_hs_a(base + 36);
        #1;
        c1 = cyc_cnt;
        if (exact_timing) check("sweep_cycles", 32'(c1 - c0), 36);
        check("sweep_done_hi", bus_a.done, 1);
        check("sweep_done_valid", bus_a.out_valid, 0);
        check("sweep_done_busy", bus_a.busy, 1);
        @(posedge clk);
        #1;
        check("sweep_done_lo", bus_a.done, 0);
        check("sweep_idle_busy", bus_a.busy, 0);
        check("sweep_done_count", done_a - dbase, 1);
        check("sweep_queue_empty", qa.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [35:0] cb;
        int          base, dbase;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0; bus_a.q_req = 1'b0; bus_a.q_pos = '0; bus_a.cell_mine = '0;
        bus_b.start = 1'b0; bus_b.q_req = 1'b0; bus_b.q_pos = '0; bus_b.cell_mine = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus_a.busy, 0);
        check("rst_valid", bus_a.out_valid, 0);
        check("rst_done", bus_a.done, 0);
        check("rst_err", bus_a.err, 0);
        check("rst_pos", bus_a.out_pos, 0);
        check("rst_count", bus_a.out_count, 0);
        check("rst_mine", bus_a.out_mine, 0);
        check("rst_busy_b", bus_b.busy, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;

        map_a = 36'h80;
        query_a(0);
        query_a(14);
        query_a(35);
        query_a(7);

        map_a = '1;
        query_a(0);
        query_a(3);
        query_a(6);
        query_a(14);

        repeat (8) begin
            map_a = 36'({$urandom, $urandom});
            query_a(int'($urandom_range(0, 35)));
        end

        for (int k = 0; k < 2; k++) begin
            bus_a.q_pos = (k == 0) ? 6'd36 : 6'd63;
            bus_a.q_req = 1'b1;
            @(posedge clk);
            #1;
            bus_a.q_req = 1'b0;
            check("err_pulse", bus_a.err, 1);
            check("err_no_valid", bus_a.out_valid, 0);
            check("err_busy", bus_a.busy, 0);
            @(posedge clk);
            #1;
            check("err_clear", bus_a.err, 0);
            check("err_no_valid_late", bus_a.out_valid, 0);
        end

        for (int p = 0; p < 36; p++) cb[p] = 1'(((p / 6) + (p % 6)) % 2);
        rdy_mode_a = 1;
        sweep_a(cb, 1'b0, 1'b0);
        rdy_mode_a = 0;

        sweep_a(36'({$urandom, $urandom}), 1'b1, 1'b1);

        base  = hs_a;
        dbase = done_a;
        map_a = 36'({$urandom, $urandom});
        bus_a.cell_mine = map_a;
        bus_a.start     = 1'b1;
        for (int p = 0; p < 36; p++) qa.push_back(ref_cell(64'(map_a), 6, 6, p));
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        wait_hs_a(base + 9);
        #1;
        rdy_mode_a = 2;
        #2;
        rst_a = 1'b1;
        #1;
        check("midrst_valid", bus_a.out_valid, 0);
        check("midrst_busy", bus_a.busy, 0);
        check("midrst_done", bus_a.done, 0);
        check("midrst_count", bus_a.out_count, 0);
        qa.delete();
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rdy_mode_a = 0;
        map_a = 36'({$urandom, $urandom});
        query_a(int'($urandom_range(0, 35)));
        query_a(21);
        check("midrst_no_done", done_a - dbase, 0);

        map_b = 32'h80;
        query_b(8);
        query_b(6);
        query_b(15);
        query_b(7);
        repeat (6) begin
            map_b = $urandom;
            query_b(int'($urandom_range(0, 31)));
        end

        repeat (3) @(posedge clk);
        check("final_queue_a", qa.size(), 0);
        check("final_queue_b", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
